// File: rtl/dmem_ecc_responder_pkg.sv
// Shared definitions for the ECC data-memory responder: codeword width,
// the word-size encoding and the transfer FSM states.
package dmem_ecc_responder_pkg;

  // Hamming codeword width: 32 data bits + 7 check bits.
  localparam int CW_W = 39;

  // Wait-state counter width (covers 0..15).
  localparam int WCNT_W = 4;

  // DSIZE encoding for a 32-bit word transfer.
  localparam logic [1:0] DSIZE_WORD = 2'b10;

  // Data-phase tracking states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no data phase pending
    ST_WAIT = 2'd1,  // counting wait states, nDWAITo low
    ST_DATA = 2'd2   // data phase completes at the next edge
  } state_e;

endpackage

// File: rtl/dmem_ecc_responder_array.sv
// Synchronous 39-bit codeword store. A read of the next accepted address and
// the write of the data phase finishing at the same edge share one clock, so
// the array exposes one write and one read address. Reads are read-first:
// a same-word write at the same edge is not visible in rdata_o.
module dmem_ecc_array
  import dmem_ecc_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [CW_W-1:0]       wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [CW_W-1:0]       rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // NOTE: the storage has no reset; only the read-data register is cleared,
  // so the array maps onto plain RAM macros.
  logic [CW_W-1:0] mem_q [DEPTH];
  logic [CW_W-1:0] rdata_q;

  // Commit write data into storage.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Capture read data on a read issue and hold it until the next one.
  // NOTE: non-blocking assignment here is what makes the read return the
  // pre-write contents when the same word is written at the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ecc_responder.sv
// Memory-side responder for the ECC-protected data-memory interface.
// Pipelined address/data phases with WAIT_CYC wait states per transfer,
// read-after-write forwarding and a one-shot codeword fault injector.
module dmem_ecc_responder
  import dmem_ecc_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT_CYC   = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            DREQi,
  input  logic [31:0]     DADDRi,
  input  logic            DRWi,
  input  logic            DLOCKi,
  input  logic [1:0]      DTYPEi,
  input  logic            DMODEi,
  input  logic [1:0]      DSIZEi,
  input  logic [CW_W-1:0] DWDATAi,
  output logic [CW_W-1:0] DRDATAo,
  output logic            nDWAITo,
  input  logic            INJ_STBi,
  input  logic [31:0]     INJ_ADDRi,
  input  logic [CW_W-1:0] INJ_MASKi,
  input  logic            INJ_PERSISTi,
  output logic            INJ_ARMEDo,
  output logic            SIZE_ERRo
);

  localparam int IDX_W = DEPTH_LOG2;
  localparam logic [WCNT_W-1:0] WAIT_LD = WCNT_W'(WAIT_CYC);

  // Transfer FSM.
  state_e            state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;

  // Transfer currently in its data phase.
  logic              pend_wr_q;
  logic [IDX_W-1:0]  pend_idx_q;
  logic              pend_hit_q;      // injector mask applies to this read
  logic              pend_clr_q;      // completing this read disarms injector
  logic [CW_W-1:0]   pend_mask_q;
  logic              pend_persist_q;
  logic              fwd_q;           // read takes fwd_data_q, not the array
  logic [CW_W-1:0]   fwd_data_q;

  // Injector.
  logic              inj_armed_q;
  logic [IDX_W-1:0]  inj_idx_q;
  logic [CW_W-1:0]   inj_mask_q;
  logic              inj_persist_q;

  logic              size_err_q;

  // Combinational datapath.
  logic              accept;
  logic              complete;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  stb_idx;
  logic              fire_clr;
  logic              eff_armed;
  logic [IDX_W-1:0]  eff_idx;
  logic [CW_W-1:0]   eff_mask;
  logic              eff_persist;
  logic              hit_new;
  logic [CW_W-1:0]   arr_rdata;
  logic [CW_W-1:0]   raw_word;
  logic              arr_we;
  logic [CW_W-1:0]   arr_wdata;
  logic              arr_re;

  // Address-phase fields with no effect on a word-only responder.
  logic unused_ok;
  assign unused_ok = ^{DLOCKi, DTYPEi, DMODEi,
                       DADDRi[31:IDX_W+2], DADDRi[1:0],
                       INJ_ADDRi[31:IDX_W+2], INJ_ADDRi[1:0]};

  assign nDWAITo  = (state_q != ST_WAIT);
  assign accept   = DREQi && (state_q != ST_WAIT);
  assign complete = (state_q == ST_DATA);
  assign req_idx  = DADDRi[IDX_W+1:2];
  assign stb_idx  = INJ_ADDRi[IDX_W+1:2];

  // Next-state logic for the data-phase tracker.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_DATA: begin
        if (accept) begin
          if (WAIT_CYC == 0) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - WCNT_W'(1);
        if (cnt_q == WCNT_W'(1)) begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Injector hit decision and array port steering.
  always_comb begin
    // A strobe arriving with a matching acceptance takes effect immediately;
    // an armed injector whose hit read completes at this edge is spent.
    fire_clr    = complete && pend_clr_q;
    eff_armed   = INJ_STBi || (inj_armed_q && !fire_clr);
    eff_idx     = INJ_STBi ? stb_idx      : inj_idx_q;
    eff_mask    = INJ_STBi ? INJ_MASKi    : inj_mask_q;
    eff_persist = INJ_STBi ? INJ_PERSISTi : inj_persist_q;
    hit_new     = accept && !DRWi && eff_armed && (req_idx == eff_idx);

    raw_word  = fwd_q ? fwd_data_q : arr_rdata;
    // Writes commit as their data phase ends; a persistent hit writes the
    // corrupted word back at the end of its (read) data phase instead.
    arr_we    = !RST && complete && (pend_wr_q || (pend_hit_q && pend_persist_q));
    arr_wdata = pend_wr_q ? DWDATAi : (raw_word ^ pend_mask_q);
    arr_re    = accept && !DRWi;
  end

  assign DRDATAo    = raw_word ^ (pend_hit_q ? pend_mask_q : '0);
  assign INJ_ARMEDo = inj_armed_q;
  assign SIZE_ERRo  = size_err_q;

  dmem_ecc_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i   (CLK),
    .rst_i   (RST),
    .we_i    (arr_we),
    .waddr_i (pend_idx_q),
    .wdata_i (arr_wdata),
    .re_i    (arr_re),
    .raddr_i (req_idx),
    .rdata_o (arr_rdata)
  );

  // FSM state and wait-state counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the accepted transfer; forward a same-edge same-word write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_wr_q      <= 1'b0;
      pend_idx_q     <= '0;
      pend_hit_q     <= 1'b0;
      pend_clr_q     <= 1'b0;
      pend_mask_q    <= '0;
      pend_persist_q <= 1'b0;
      fwd_q          <= 1'b0;
      fwd_data_q     <= '0;
    end else if (accept) begin
      pend_wr_q      <= DRWi;
      pend_idx_q     <= req_idx;
      pend_hit_q     <= hit_new;
      pend_clr_q     <= hit_new;
      pend_mask_q    <= eff_mask;
      pend_persist_q <= eff_persist;
      if (!DRWi) begin
        fwd_q      <= arr_we && (pend_idx_q == req_idx);
        fwd_data_q <= arr_wdata;
      end
    end else if (complete) begin
      pend_wr_q  <= 1'b0;
      pend_hit_q <= 1'b0;
      pend_clr_q <= 1'b0;
    end else if (INJ_STBi) begin
      // A re-strobe during a hit read's wait states must stay armed.
      pend_clr_q <= 1'b0;
    end
  end

  // Injector arm/fire registers; a strobe always wins over a same-edge fire.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inj_armed_q   <= 1'b0;
      inj_idx_q     <= '0;
      inj_mask_q    <= '0;
      inj_persist_q <= 1'b0;
    end else if (INJ_STBi) begin
      inj_armed_q   <= 1'b1;
      inj_idx_q     <= stb_idx;
      inj_mask_q    <= INJ_MASKi;
      inj_persist_q <= INJ_PERSISTi;
    end else if (fire_clr) begin
      inj_armed_q   <= 1'b0;
    end
  end

  // Sticky flag for accepted non-word requests.
  always_ff @(posedge CLK) begin
    if (RST) begin
      size_err_q <= 1'b0;
    end else if (accept && (DSIZEi != DSIZE_WORD)) begin
      size_err_q <= 1'b1;
    end
  end

endmodule
